mmio_periph: RTL
================

# mmio_periph

Memory-mapped peripheral block sitting directly downstream of the CPU MEM stage. It decodes word accesses whose address has bit 30 set and returns read data combinationally in the same cycle. It holds the interval timer, LED/switch/7-segment registers and a UART register file, and drives the timer interrupt request back to the CPU's PC-select logic.

## Interface
- BAUD_DIV, 5208: clocks per UART bit (50 MHz / 9600).
- reset  in  1  asynchronous, active-low reset.
- clk  in  1  clock.
- rd  in  1  MEM-stage read strobe.
- wr  in  1  MEM-stage write strobe.
- addr  in  32  byte address; only [5:2] decoded.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational.
- pc_kernel  in  1  PC[31] of the stage in flight; 1 = kernel mode.
- irq  out  1  timer interrupt request.
- switch  in  8  board switches, sampled directly.
- led  out  8  LED register.
- digi  out  12  [11:8] anode enables (active-low), [7:0] segments.
- uart_rx  in  1  serial in.
- uart_tx  out  1  serial out, idle high.

## Operation
- Address map (offset from 0x40000000): 0x00 TH, 0x04 TL, 0x08 TCON[2:0], 0x0C LED[7:0], 0x10 SWITCH[7:0] (RO), 0x14 DIGI[11:0], 0x18 TXD[7:0], 0x1C RXD[7:0] (RO), 0x20 UCON[2:0].
- Unmapped offsets: reads return 0, writes ignored. rdata = 0 whenever rd = 0. Narrow registers are zero-extended on read.
- Timer: when TCON[0] = 1, TL increments each clk. When TL = 0xFFFFFFFF: TL <= TH, and TCON[2] (status) <= 1 if TCON[1] (irq enable) = 1.
- irq = TCON[2] & TCON[1] & ~pc_kernel. The handler clears TCON[2] by writing TCON.
- TXD write with UCON[0] (tx_busy) = 0 latches the byte and starts an 8N1 frame: start bit 0, 8 data bits LSB first, stop bit 1, each bit BAUD_DIV clocks. A TXD write while busy is ignored.
- RX: uart_rx passes through a 2-FF synchroniser. A falling edge while idle starts a frame; the start bit is re-checked at BAUD_DIV/2 (back to idle if high), then each data bit is sampled every BAUD_DIV clocks, then the stop bit.
  - Stop = 1: byte goes to RXD and UCON[1] (rx_valid) <= 1. If rx_valid was already 1, UCON[2] (overrun) <= 1.
  - Stop = 0: frame discarded.
- Reading RXD (rd & offset 0x1C) clears rx_valid at the clock edge. Writing UCON with wdata[2] = 1 clears overrun. Bits [1:0] of UCON are read-only.
- TX FSM states: IDLE → START → DATA (bit counter 0..7) → STOP → IDLE.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
- Simultaneous events:
  - A write to TL or TH in the same cycle as an overflow: the software write wins.
  - Overflow setting TCON[2] in the same cycle as a software TCON write: the write sets bits [1:0], and status = written bit2 | overflow-set.
  - An RXD read in the same cycle as a new byte completing: the new byte is stored and rx_valid stays 1.
  - rd and wr both high: the write is performed and rdata shows the old value.
- Reset values:
  - TH, TL, TCON, LED = 0; DIGI = 12'hFFF (display off); RXD = 0; UCON = 0.
  - uart_tx = 1; irq = 0; both FSMs in IDLE.
- Reset mid-frame aborts the frame immediately. uart_tx returns to 1 asynchronously.

## Timing
- Reads have zero latency: rdata is valid in the same cycle as rd/addr.
- Writes take effect at the rising clk edge where wr = 1. The new value is visible the next cycle.
- Timer overflow at edge k: TL = TH and TCON[2] = 1 after edge k. irq rises combinationally in the cycle that follows.
- TX: uart_tx falls on the edge after the TXD write. tx_busy = 1 from that edge for 10*BAUD_DIV clocks.
- RX: rx_valid rises 2 (synchroniser) + BAUD_DIV/2 + 9*BAUD_DIV clocks after the falling edge on the pin, ±1.

## Structure
- Shared package: address offset constants, TCON/UCON bit indices, and TX/RX FSM state enums.
- One sub-module, uart_core, holds the baud counters, the TX/RX FSMs, the synchroniser, and the tx_busy/rx_valid handshakes.
- mmio_periph keeps the register file, the timer and the read mux.

## Test plan
- Timer reload: TH = 0xFFFFFFFE, TL = 0xFFFFFFFE, TCON = 3 → TL = 0xFFFFFFFF, then 0xFFFFFFFE with TCON[2] = 1, irq = 1. With pc_kernel = 1, irq = 0. Write TCON = 3 → irq drops.
- Registers:
  - Write LED = 0xA5 → led = 0xA5, read returns 0x000000A5.
  - switch = 0x3C → read 0x10 returns 0x3C.
  - Write DIGI = 0x7E6 → digi = 0x7E6.
  - Read 0x24 → 0.
- TX with BAUD_DIV = 4: write TXD = 0x55 → uart_tx sequence 0,1,0,1,0,1,0,1,0,1, 4 clocks per bit.
  - UCON[0] = 1 for 40 clocks.
  - A second TXD write mid-frame is ignored.
- RX with BAUD_DIV = 4:
  - Drive frame 0xC3 → RXD = 0xC3, UCON = 0x2. Read RXD → UCON = 0.
  - Two frames without a read → UCON = 0x6. Write UCON = 4 → UCON = 0x2.
  - A frame with stop = 0 is discarded.
- Reset mid-TX frame: uart_tx = 1, UCON = 0, all registers at reset values. A new TXD write then starts a clean frame.

Source files
------------

// File: rtl/mmio_periph_pkg.sv
// Shared constants and types for the memory-mapped peripheral block.
package mmio_periph_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 4;

  // Word offsets, addr[5:2]
  localparam logic [OFF_W-1:0] OFF_TH     = 4'h0;
  localparam logic [OFF_W-1:0] OFF_TL     = 4'h1;
  localparam logic [OFF_W-1:0] OFF_TCON   = 4'h2;
  localparam logic [OFF_W-1:0] OFF_LED    = 4'h3;
  localparam logic [OFF_W-1:0] OFF_SWITCH = 4'h4;
  localparam logic [OFF_W-1:0] OFF_DIGI   = 4'h5;
  localparam logic [OFF_W-1:0] OFF_TXD    = 4'h6;
  localparam logic [OFF_W-1:0] OFF_RXD    = 4'h7;
  localparam logic [OFF_W-1:0] OFF_UCON   = 4'h8;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_ST = 2;

  localparam int unsigned UCON_TX_BUSY  = 0;
  localparam int unsigned UCON_RX_VALID = 1;
  localparam int unsigned UCON_OVR      = 2;

  localparam logic [11:0] DIGI_RESET = 12'hFFF;

  typedef struct packed {
    logic overrun;
    logic rx_valid;
    logic tx_busy;
  } ucon_t;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/mmio_periph_uart_core.sv
// 8N1 UART: baud counters, TX/RX FSMs, input synchroniser and status handshakes.
module uart_core
  import mmio_periph_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       rx_ack,
  input  logic       ovr_clr,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

  tx_state_t        tx_state, tx_state_n;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]       tx_bit, tx_bit_n;
  logic [7:0]       tx_shift, tx_shift_n;
  logic             tx_line_n, tx_busy_n;

  rx_state_t        rx_state, rx_state_n;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]       rx_bit, rx_bit_n;
  logic [7:0]       rx_shift, rx_shift_n;
  logic [7:0]       rx_data_n;
  logic             rx_valid_n, rx_overrun_n;
  logic             rx_s1, rx_s2, rx_prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      uart_tx  <= tx_line_n;
      tx_busy  <= tx_busy_n;
    end
  end

  // TX: the line value for the next bit is registered together with the state
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + CNT_W'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_line_n  = uart_tx;
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n  = '0;
        tx_line_n = 1'b1;
        if (tx_start) begin
          tx_state_n = TX_START;
          tx_shift_n = tx_data;
          tx_line_n  = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            tx_line_n  = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_line_n  = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = '0;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = '0;
        tx_line_n  = 1'b1;
      end
    endcase
    tx_busy_n = (tx_state_n != TX_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_s1      <= uart_rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      rx_state   <= rx_state_n;
      rx_cnt     <= rx_cnt_n;
      rx_bit     <= rx_bit_n;
      rx_shift   <= rx_shift_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      rx_overrun <= rx_overrun_n;
    end
  end

  // RX: start bit re-checked at half a bit, later bits sampled at their centres
  always_comb begin
    logic byte_done;
    byte_done    = 1'b0;
    rx_state_n   = rx_state;
    rx_cnt_n     = rx_cnt + CNT_W'(1);
    rx_bit_n     = rx_bit;
    rx_shift_n   = rx_shift;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          byte_done  = rx_s2;
        end
      end
      default: begin
        rx_state_n = RX_IDLE;
        rx_cnt_n   = '0;
      end
    endcase

    rx_data_n    = rx_data;
    rx_valid_n   = rx_valid & ~rx_ack;
    rx_overrun_n = rx_overrun & ~ovr_clr;
    if (byte_done) begin
      rx_data_n  = rx_shift;
      rx_valid_n = 1'b1;
      if (rx_valid) rx_overrun_n = 1'b1;
    end
  end

endmodule

// File: rtl/mmio_periph.sv
// Memory-mapped peripheral: timer, LED/switch/7-seg registers, UART, combinational read mux.
module mmio_periph
  import mmio_periph_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic              reset,
  input  logic              clk,
  input  logic              rd,
  input  logic              wr,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              pc_kernel,
  output logic              irq,
  input  logic [7:0]        switch,
  output logic [7:0]        led,
  output logic [11:0]       digi,
  input  logic              uart_rx,
  output logic              uart_tx
);

  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] th, tl, rd_mux;
  logic [2:0]        tcon;
  logic              wr_th, wr_tl, wr_tcon, ovf, ovf_set;
  logic              tx_busy, rx_valid, rx_overrun;
  logic [7:0]        rx_data;
  ucon_t             ucon_c;
  logic              unused_addr_bits;

  assign off              = addr[5:2];
  assign unused_addr_bits = ^{addr[31:6], addr[1:0]};

  assign wr_th   = wr && (off == OFF_TH);
  assign wr_tl   = wr && (off == OFF_TL);
  assign wr_tcon = wr && (off == OFF_TCON);
  assign ovf     = tcon[TCON_EN] && (tl == '1);
  assign ovf_set = ovf && tcon[TCON_IE];

  assign irq = tcon[TCON_ST] & tcon[TCON_IE] & ~pc_kernel;

  // Timer and board registers; software writes take priority over reload
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
      led  <= '0;
      digi <= DIGI_RESET;
    end else begin
      if (wr_th) th <= wdata;
      if (wr_tl)                tl <= wdata;
      else if (ovf)             tl <= th;
      else if (tcon[TCON_EN])   tl <= tl + 32'd1;
      if (wr_tcon)      tcon <= {wdata[TCON_ST] | ovf_set, wdata[1:0]};
      else if (ovf_set) tcon[TCON_ST] <= 1'b1;
      if (wr && (off == OFF_LED))  led  <= wdata[7:0];
      if (wr && (off == OFF_DIGI)) digi <= wdata[11:0];
    end
  end

  assign ucon_c = '{overrun: rx_overrun, rx_valid: rx_valid, tx_busy: tx_busy};

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_TH:     rd_mux = th;
      OFF_TL:     rd_mux = tl;
      OFF_TCON:   rd_mux = DATA_W'(tcon);
      OFF_LED:    rd_mux = DATA_W'(led);
      OFF_SWITCH: rd_mux = DATA_W'(switch);
      OFF_DIGI:   rd_mux = DATA_W'(digi);
      OFF_RXD:    rd_mux = DATA_W'(rx_data);
      OFF_UCON:   rd_mux = DATA_W'(ucon_c);
      default:    rd_mux = '0;
    endcase
    rdata = rd ? rd_mux : '0;
  end

  uart_core #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .reset      (reset),
    .tx_start   (wr && (off == OFF_TXD) && !tx_busy),
    .tx_data    (wdata[7:0]),
    .rx_ack     (rd && (off == OFF_RXD)),
    .ovr_clr    (wr && (off == OFF_UCON) && wdata[UCON_OVR]),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_overrun (rx_overrun)
  );

endmodule
